seq_arith_8b_serial_sub: RTL and testbench
==========================================

Name: seq_arith_8b_serial_sub

Overview:
- Bit-serial, multi-cycle subtractor computing out = in0 - in1 (mod 2^NBITS) plus a signed-overflow flag.
- Serves as the subtract-direction counterpart of the team's 8-bit combinational adder in the arithmetic block set.
- Trades latency for area: processes one bit per cycle, LSB first, through a single 1-bit full-subtractor cell.
- Operands enter and results leave via val/rdy handshakes.

Parameters:
- NBITS, 8, operand and result width; legal range 2 to 32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  one clock; reset is asynchronous and active-low. Asserting reset (reset=0) clears all state immediately.
- in_val  input  1  operand pair valid.
- in_rdy  output  1  block can accept an operand pair.
- in0  input  NBITS  minuend (two's complement).
- in1  input  NBITS  subtrahend (two's complement).
- out_val  output  1  result valid.
- out_rdy  input  1  consumer accepts the result.
- out  output  NBITS  difference, in0 - in1 mod 2^NBITS.
- overflow  output  1  signed overflow of the subtraction.

Behaviour:
- States:
  - IDLE: in_rdy=1, out_val=0.
  - CALC: in_rdy=0, out_val=0.
  - DONE: in_rdy=0, out_val=1.
- Reset (reset=0, asynchronous): state=IDLE; operand shift registers, result register, borrow flop, bit counter and overflow all cleared to 0. Resulting outputs: in_rdy=1, out_val=0, out=0, overflow=0. Any in-flight operation is discarded with no output.
- IDLE -> CALC on an edge with in_val & in_rdy:
  - latch in0/in1 into shift registers;
  - borrow=0, counter=0;
  - capture the sign bits of in0 and in1 for overflow.
- CALC, each edge (one bit per edge, LSB first):
  - a = in0_sr[0], b = in1_sr[0];
  - diff = a ^ b ^ borrow;
  - borrow_next = (~a & b) | (~(a ^ b) & borrow);
  - diff shifts into the result register MSB (right-shift), so after NBITS shifts bit 0 lands at out[0];
  - operand registers shift right; counter increments.
- CALC -> DONE on the edge where counter == NBITS-1, i.e. the NBITS-th CALC edge.
- Latency: acceptance at edge E gives out_val=1 after edge E+NBITS.
- Final carry: the borrow out of the MSB is discarded (mod-2^NBITS wrap).
- overflow = (sign(in0) != sign(in1)) & (out[NBITS-1] != sign(in0)). It is registered and valid only while out_val=1, and held 0 otherwise.
- DONE:
  - out and overflow are held stable while out_val=1 & out_rdy=0, for unbounded backpressure.
  - On out_rdy=1: state -> IDLE, out_val drops, in_rdy rises after that same edge. The result register is not cleared.
- No overlap: in_rdy=0 during CALC and DONE, including the edge on which out_rdy completes DONE.
  - Minimum initiation interval is NBITS+2 cycles (accept, NBITS CALC, DONE with out_rdy=1).
- in_val while in_rdy=0 is ignored, and in0/in1 are not sampled.
- Input handshakes are edge-accurate: exactly one operation per in_val&in_rdy edge.
- in0/in1 may change freely after acceptance.

Decomposition:
- Package seq_arith_pkg:
  - state enum {IDLE, CALC, DONE} (2-bit);
  - counter-width function clog2(NBITS).
- One sub-module, full_sub_1b: inputs a, b, bin; outputs d, bout; purely combinational.
- The top module holds the FSM, counter, shift registers and overflow logic.

Test Plan:
- Reset then in0=42, in1=13, in_val=1 for one cycle, out_rdy=1 -> out_val exactly 8 cycles after acceptance; out=29 (0x1D); overflow=0; back in IDLE (in_rdy=1) the next cycle.
- Negative and wrap cases: 0-1 -> 0xFF, ovf=0. -42-(-13) -> 0xE3 (-29), ovf=0. -128-(-128) -> 0x00, ovf=0.
- Overflow cases: -128-1 -> 0x7F, ovf=1. 127-(-1) -> 0x80, ovf=1. 120-(-13) -> 0x85, ovf=1. -120-13 -> 0x7B, ovf=1.
- Backpressure: 100-27 with out_rdy=0 for 5 cycles after out_val rises -> out=0x49 and out_val held stable for all 5 cycles. in_rdy=0 throughout and a second in_val is ignored. Release out_rdy -> one handshake, then in_rdy=1.
- Reset mid-CALC: accept 42-13, drop reset to 0 at a non-clock-aligned time 3 cycles later -> in_rdy=1 and out_val=0 immediately. After reset deassertion, a new pair 5-7 -> 0xFE, with no stale result emitted.
- Random: 20 pairs of $urandom operands, back-to-back with in_val held high and random out_rdy -> each out matches (in0-in1) mod 256 and its overflow flag. Exactly 20 output handshakes, in order.

Source files
------------

// File: rtl/seq_arith_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   state_t : FSM encoding (IDLE, CALC, DONE), 2 bits
//   clog2() : bit-counter width for a given operand width (at least 1)
package seq_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to count 0..n-1. Elaboration-time only.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_arith_8b_serial_sub_if.sv
// Operand/result handshake bundle for the serial subtractor.
//   in_val/in_rdy/in0/in1      : operand pair handshake (producer -> block)
//   out_val/out_rdy/out/overflow : result handshake (block -> consumer)
// master = producer/consumer side, slave = subtractor side.
interface seq_arith_8b_serial_sub_if #(
  parameter int NBITS = 8
);
  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in0;
  logic [NBITS-1:0] in1;
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] out;
  logic             overflow;

  modport master (
    output in_val, in0, in1, out_rdy,
    input  in_rdy, out_val, out, overflow
  );

  modport slave (
    input  in_val, in0, in1, out_rdy,
    output in_rdy, out_val, out, overflow
  );
endinterface

// File: rtl/full_sub_1b.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
//   a, b, bin : operand bits and borrow in
//   d, bout   : difference bit and borrow out
module full_sub_1b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/seq_arith_8b_serial_sub.sv
// Bit-serial subtractor: out = in0 - in1 (mod 2^NBITS) with signed overflow.
// One bit per cycle, LSB first, through a single full_sub_1b cell.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low clear of all state
//   bus   : operand/result handshakes (slave modport)
//
// state | meaning
// IDLE  | waiting for an operand pair, in_rdy=1
// CALC  | shifting NBITS bits through the subtractor cell
// DONE  | result valid, held until out_rdy
module seq_arith_8b_serial_sub
  import seq_arith_pkg::*;
#(
  parameter int NBITS = 8
) (
  input logic                      clk,
  input logic                      reset,
  seq_arith_8b_serial_sub_if.slave bus
);

  localparam int CW = clog2(NBITS);

  state_t           state, state_nxt;
  logic [NBITS-1:0] in0_sr, in1_sr, res;
  logic [CW-1:0]    cnt;
  logic             borrow, sign0, sign1, ovf_q;
  logic             accept, last, d, bout;

  full_sub_1b u_fs (
    .a    (in0_sr[0]),
    .b    (in1_sr[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  assign last         = (cnt == CW'(NBITS - 1));
  assign bus.out      = res;
  assign bus.overflow = ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.in_rdy  = 1'b0;
    bus.out_val = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_rdy = 1'b1;
        accept     = bus.in_val;
        if (bus.in_val) state_nxt = CALC;
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.out_val = 1'b1;
        if (bus.out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in0_sr <= '0;
      in1_sr <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      sign0  <= 1'b0;
      sign1  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        in0_sr <= bus.in0;
        in1_sr <= bus.in1;
        cnt    <= '0;
        borrow <= 1'b0;
        sign0  <= bus.in0[NBITS-1];
        sign1  <= bus.in1[NBITS-1];
        ovf_q  <= 1'b0;
      end else if (state == CALC) begin
        in0_sr <= in0_sr >> 1;
        in1_sr <= in1_sr >> 1;
        res    <= {d, res[NBITS-1:1]};
        borrow <= bout;
        cnt    <= cnt + CW'(1);
        // The bit entering on the last edge is the result sign bit.
        if (last) ovf_q <= (sign0 ^ sign1) & (d ^ sign0);
      end else if (state == DONE && bus.out_rdy) begin
        // Flag is only meaningful while out_val is high.
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_arith_8b_serial_sub.sv
module tb_seq_arith_8b_serial_sub;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  seq_arith_8b_serial_sub_if #(.NBITS(8)) bus ();

  seq_arith_8b_serial_sub #(.NBITS(8)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       o;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] df;
    df = a - b;
    return {(a[7] != b[7]) && (df[7] != a[7]), df};
  endfunction

  // One operation with out_rdy held high; checks latency, result, return to IDLE.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_o);
    int lat;
    @(negedge clk);
    check({name, " in_rdy before"}, bus.in_rdy, 1);
    bus.in0 = a; bus.in1 = b; bus.in_val = 1'b1; bus.out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_val = 1'b0; bus.in0 = ~a; bus.in1 = ~b;
    check({name, " in_rdy in calc"}, bus.in_rdy, 0);
    lat = 0;
    while (!bus.out_val && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, 8);
    check({name, " out"}, bus.out, exp_d);
    check({name, " ovf"}, bus.overflow, exp_o);
    @(negedge clk);
    check({name, " in_rdy after"}, bus.in_rdy, 1);
    check({name, " out_val after"}, bus.out_val, 0);
    check({name, " ovf after"}, bus.overflow, 0);
  endtask

  initial begin
    logic [8:0] expq[$];
    logic [8:0] e;
    int sent, got, cyc, extra, lat;
    bit pend;

    vecs[0] = '{"42-13",     8'd42,  8'd13,  8'h1D, 1'b0};
    vecs[1] = '{"0-1",       8'h00,  8'h01,  8'hFF, 1'b0};
    vecs[2] = '{"-42-(-13)", 8'hD6,  8'hF3,  8'hE3, 1'b0};
    vecs[3] = '{"-128-(-128)", 8'h80, 8'h80, 8'h00, 1'b0};
    vecs[4] = '{"-128-1",    8'h80,  8'h01,  8'h7F, 1'b1};
    vecs[5] = '{"127-(-1)",  8'h7F,  8'hFF,  8'h80, 1'b1};
    vecs[6] = '{"120-(-13)", 8'h78,  8'hF3,  8'h85, 1'b1};
    vecs[7] = '{"-120-13",   8'h88,  8'h0D,  8'h7B, 1'b1};

    passed = 0; total = 0;
    bus.in_val = 1'b0; bus.in0 = '0; bus.in1 = '0; bus.out_rdy = 1'b0;
    rst = 1'b0;
    #1;
    check("reset in_rdy", bus.in_rdy, 1);
    check("reset out_val", bus.out_val, 0);
    check("reset out", bus.out, 0);
    check("reset ovf", bus.overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].o);

    // Backpressure: 100-27 held for 5 cycles, a second in_val ignored.
    @(negedge clk);
    bus.in0 = 8'd100; bus.in1 = 8'd27; bus.in_val = 1'b1; bus.out_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in0 = 8'd1; bus.in1 = 8'd2;
    lat = 0;
    while (!bus.out_val && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      check("bp out_val held", bus.out_val, 1);
      check("bp out held", bus.out, 8'h49);
      check("bp ovf held", bus.overflow, 0);
      check("bp in_rdy low", bus.in_rdy, 0);
      @(negedge clk);
    end
    bus.in_val = 1'b0; bus.out_rdy = 1'b1;
    @(negedge clk);
    check("bp release out_val", bus.out_val, 0);
    check("bp release in_rdy", bus.in_rdy, 1);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_val) extra++;
    end
    check("bp no stray result", extra, 0);

    // Reset in the middle of CALC.
    @(negedge clk);
    bus.in0 = 8'd42; bus.in1 = 8'd13; bus.in_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_val = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midreset in_rdy", bus.in_rdy, 1);
    check("midreset out_val", bus.out_val, 0);
    check("midreset out", bus.out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_op("5-7", 8'd5, 8'd7, 8'hFE, 1'b0);

    // Random back-to-back stream with random out_rdy.
    sent = 0; got = 0; cyc = 0; pend = 0;
    @(negedge clk);
    bus.in0 = 8'($urandom); bus.in1 = 8'($urandom); bus.in_val = 1'b1;
    while ((sent < 20 || got < 20) && cyc < 3000) begin
      if (pend) begin
        pend = 0;
        if (sent < 20) begin
          bus.in0 = 8'($urandom); bus.in1 = 8'($urandom);
        end else begin
          bus.in_val = 1'b0;
        end
      end
      bus.out_rdy = ($urandom_range(0, 1) == 1);
      if (bus.out_val && bus.out_rdy) begin
        if (expq.size() == 0) begin
          check("rand pending expectations", expq.size(), 1);
        end else begin
          e = expq.pop_front();
          check("rand out", bus.out, e[7:0]);
          check("rand ovf", bus.overflow, e[8]);
        end
        got++;
      end
      if (bus.in_val && bus.in_rdy && sent < 20) begin
        expq.push_back(model(bus.in0, bus.in1));
        sent++;
        pend = 1;
      end
      @(negedge clk);
      cyc++;
    end
    check("rand sent", sent, 20);
    check("rand received", got, 20);
    bus.in_val = 1'b0; bus.out_rdy = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_val) extra++;
    end
    check("rand no extra output", extra, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
